modulo_gerenciador_estoque_rolhas: RTL and testbench
====================================================

// Module: modulo_gerenciador_estoque_rolhas
// PURPOSE
//  Parametrised cork-stock manager for the filling/sealing line. Holds a principal stock
//  (feeds the sealing station) and a secondary stock (operator-loaded reserve).
//  Auto-transfers a batch secondary->principal when principal reaches its minimum.
//  Loads operator quantities unit-by-unit. Drives ro/min flags to the sealing MEF and the display path.
// PARAMETERS
//  CNT_W        7   stock counter width; 2**CNT_W > max(CAP_PRINC,CAP_SEC)
//  CAP_PRINC   99   principal stock capacity (units)
//  CAP_SEC     99   secondary stock capacity (units)
//  MIN_PRINC    5   principal threshold that triggers auto-transfer
//  LOTE_TRANSF 15   max units moved per auto-transfer
// PORTS
//  clk              in   1      system clock (divided clock domain)
//  clr_n            in   1      asynchronous reset, active-low
//  enable           in   1      line running (start_stop); 0 freezes all activity
//  consumo          in   1      1 = one cork consumed this cycle (ve & cq qualified upstream)
//  op_carga         in   1      single-cycle operator load request (debounced, pulsed upstream)
//  op_qtd           in   CNT_W  quantity requested with op_carga
//  qtd_principal    out  CNT_W  principal stock count
//  qtd_secundario   out  CNT_W  secondary stock count
//  ro               out  1      principal empty (qtd_principal==0)
//  min_principal    out  1      qtd_principal <= MIN_PRINC
//  busy             out  1      FSM not in OCIOSO
//  carga_rejeitada  out  1      one-cycle pulse: load request refused
//  transf_fim       out  1      one-cycle pulse: auto-transfer completed
// BEHAVIOUR
//  - Reset (clr_n=0, async): both counts 0, FSM=OCIOSO, all outputs 0 except ro=1, min_principal=1.
//  - All registers update on posedge clk. ro/min_principal/busy are combinational from registered state.
//  - FSM states:
//    - OCIOSO -> TRANSFERE when enable & min_principal & qtd_secundario>0.
//      Load rem = min(LOTE_TRANSF, qtd_secundario, CAP_PRINC-qtd_principal); rem==0 stays OCIOSO.
//    - OCIOSO -> CARGA when enable & op_carga & op_qtd!=0 & qtd_secundario+op_qtd<=CAP_SEC
//      (sum computed CNT_W+1 wide). Load rem=op_qtd.
//    - TRANSFERE: each enabled cycle principal+1, secundario-1, rem-1. rem reaches 0 -> OCIOSO,
//      transf_fim pulses on the cycle after the last unit.
//    - CARGA: each enabled cycle secundario+1, rem-1. rem reaches 0 -> OCIOSO.
//  - Priority in OCIOSO: transfer start beats op_carga. op_carga is rejected
//    (carga_rejeitada=1 next cycle) when:
//    - busy, or transfer starts the same cycle;
//    - enable=0;
//    - op_qtd==0;
//    - the sum exceeds CAP_SEC.
//  - Consumption: enable & consumo & qtd_principal>0 -> principal-1.
//    - consumo while principal==0 is ignored; never wraps below 0.
//    - Same cycle as a transfer unit: principal net unchanged, secundario-1.
//  - Saturation: counters never exceed CAP_*; no wrap-around in either direction.
//  - enable=0: FSM holds state and rem; counts frozen; consumption ignored; resumes where it stopped.
//  - Reset mid-transfer/mid-load: partial units already moved are lost; everything returns to reset values.
// STRUCTURE
//  - Package pkg_rolhas:
//    - typedef enum {OCIOSO, TRANSFERE, CARGA} estado_rolhas_t;
//    - default constants for CAP/MIN/LOTE shared with the display encoders.
//  - One sub-module: modulo_contador_ud_sat, a parametrised up/down counter
//    (CNT_W, MAX; clk, clr_n, en, up, dn; saturating, up&dn = hold).
//    Instantiated twice, for principal and secondary.
//  - rem counter, batch-size min() logic and FSM live in this module.
// TESTING
//  1 Reset: clr_n=0 mid-CARGA -> counts 0, ro=1, min_principal=1, busy=0 immediately (async).
//  2 Load: op_carga, op_qtd=20 from reset -> busy 20 cycles, qtd_secundario=20.
//    Then auto-transfer of 15: principal=15, secundario=5, transf_fim one pulse.
//  3 Limited batch: principal=5, secundario=3 -> transfer moves 3; principal=8, secundario=0;
//    no further transfer while secundario==0.
//  4 Rejects: secundario=90 + op_qtd=10 -> carga_rejeitada pulse, counts unchanged;
//    op_carga during TRANSFERE -> rejected; op_qtd=0 -> rejected.
//  5 Simultaneous: consumo=1 every cycle during transfer of 15 from principal=5 ->
//    principal stays 5 and secundario drops 15; consumo at principal=0 -> stays 0, ro=1.
//  6 Freeze: enable=0 for 10 cycles mid-transfer (rem=7) -> counts/state held;
//    enable=1 -> exactly 7 more units move.

Source files
------------

// File: rtl/modulo_gerenciador_estoque_rolhas_pkg.sv
// pkg_rolhas: FSM states and default stock constants shared with the display encoders
package pkg_rolhas;
    typedef enum logic [1:0] {OCIOSO, TRANSFERE, CARGA} estado_rolhas_t;
    localparam int CNT_W_PAD       = 7;
    localparam int CAP_PRINC_PAD   = 99;
    localparam int CAP_SEC_PAD     = 99;
    localparam int MIN_PRINC_PAD   = 5;
    localparam int LOTE_TRANSF_PAD = 15;
endpackage

// File: rtl/modulo_contador_ud_sat.sv
// modulo_contador_ud_sat: saturating up/down counter, up and dn together hold the count
module modulo_contador_ud_sat #(
    parameter int CNT_W = 7,
    parameter int MAX   = 99
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             en,
    input  logic             up,
    input  logic             dn,
    output logic [CNT_W-1:0] qtd
);
    localparam logic [CNT_W-1:0] MAX_Q = CNT_W'(MAX);
    always_ff @(posedge clk or negedge clr_n)
        if (!clr_n)
            qtd <= '0;
        else if (en && up && !dn && qtd != MAX_Q)
            qtd <= qtd + 1'b1;
        else if (en && dn && !up && qtd != '0)
            qtd <= qtd - 1'b1;
endmodule

// File: rtl/modulo_gerenciador_estoque_rolhas.sv
// modulo_gerenciador_estoque_rolhas: principal/secondary cork stock with auto-transfer and operator load
module modulo_gerenciador_estoque_rolhas
    import pkg_rolhas::*;
#(
    parameter int CNT_W       = CNT_W_PAD,
    parameter int CAP_PRINC   = CAP_PRINC_PAD,
    parameter int CAP_SEC     = CAP_SEC_PAD,
    parameter int MIN_PRINC   = MIN_PRINC_PAD,
    parameter int LOTE_TRANSF = LOTE_TRANSF_PAD
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             enable,
    input  logic             consumo,
    input  logic             op_carga,
    input  logic [CNT_W-1:0] op_qtd,
    output logic [CNT_W-1:0] qtd_principal,
    output logic [CNT_W-1:0] qtd_secundario,
    output logic             ro,
    output logic             min_principal,
    output logic             busy,
    output logic             carga_rejeitada,
    output logic             transf_fim
);
    localparam logic [CNT_W-1:0] CAP_P  = CNT_W'(CAP_PRINC);
    localparam logic [CNT_W-1:0] MIN_P  = CNT_W'(MIN_PRINC);
    localparam logic [CNT_W-1:0] LOTE_Q = CNT_W'(LOTE_TRANSF);
    localparam logic [CNT_W:0]   CAP_S  = (CNT_W+1)'(CAP_SEC);

    estado_rolhas_t   estado, estado_next;
    logic [CNT_W-1:0] rem, rem_next, vaga, lote_a, lote;
    logic [CNT_W:0]   soma;
    logic             ocioso, passo, ultimo, inicia_transf, inicia_carga;

    always_comb begin
        vaga          = CAP_P - qtd_principal;
        lote_a        = LOTE_Q < qtd_secundario ? LOTE_Q : qtd_secundario;
        lote          = vaga < lote_a ? vaga : lote_a;
        soma          = {1'b0, qtd_secundario} + {1'b0, op_qtd};
        ocioso        = estado == OCIOSO;
        inicia_transf = enable && ocioso && min_principal && lote != '0;
        inicia_carga  = enable && ocioso && op_carga && op_qtd != '0 && soma <= CAP_S && !inicia_transf;
        passo         = enable && !ocioso;
        ultimo        = passo && rem == CNT_W'(1);
        estado_next   = inicia_transf ? TRANSFERE : inicia_carga ? CARGA : ultimo ? OCIOSO : estado;
        rem_next      = inicia_transf ? lote : inicia_carga ? op_qtd : passo ? rem - 1'b1 : rem;
    end

    always_ff @(posedge clk or negedge clr_n)
        if (!clr_n) begin
            estado          <= OCIOSO;
            rem             <= '0;
            carga_rejeitada <= 1'b0;
            transf_fim      <= 1'b0;
        end else begin
            estado          <= estado_next;
            rem             <= rem_next;
            carga_rejeitada <= op_carga && !inicia_carga;
            transf_fim      <= ultimo && estado == TRANSFERE;
        end

    assign ro            = qtd_principal == '0;
    assign min_principal = qtd_principal <= MIN_P;
    assign busy          = !ocioso;

    // consumption is gated at zero so it cannot cancel a transfer unit into an empty stock
    modulo_contador_ud_sat #(.CNT_W(CNT_W), .MAX(CAP_PRINC)) u_principal (
        .clk(clk), .clr_n(clr_n), .en(enable),
        .up(estado == TRANSFERE), .dn(consumo && !ro), .qtd(qtd_principal)
    );

    modulo_contador_ud_sat #(.CNT_W(CNT_W), .MAX(CAP_SEC)) u_secundario (
        .clk(clk), .clr_n(clr_n), .en(enable),
        .up(estado == CARGA), .dn(estado == TRANSFERE), .qtd(qtd_secundario)
    );
endmodule

// File: tb/tb_modulo_gerenciador_estoque_rolhas.sv
// tb_modulo_gerenciador_estoque_rolhas: directed self-checking bench for the cork stock manager
module tb_modulo_gerenciador_estoque_rolhas;
    logic       clk = 0, clr_n = 0, enable = 0, consumo = 0, op_carga = 0;
    logic [6:0] op_qtd = 0;
    logic [6:0] qtd_principal, qtd_secundario;
    logic       ro, min_principal, busy, carga_rejeitada, transf_fim;
    int         checks = 0, passes = 0, n;

    modulo_gerenciador_estoque_rolhas dut (
        .clk(clk), .clr_n(clr_n), .enable(enable), .consumo(consumo),
        .op_carga(op_carga), .op_qtd(op_qtd),
        .qtd_principal(qtd_principal), .qtd_secundario(qtd_secundario),
        .ro(ro), .min_principal(min_principal), .busy(busy),
        .carga_rejeitada(carga_rejeitada), .transf_fim(transf_fim)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick(input int k = 1);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(output int c);
        c = 0;
        while (busy && c < 300) begin
            tick();
            c++;
        end
    endtask

    task automatic carga(input int q);
        op_carga = 1;
        op_qtd   = q[6:0];
        tick();
        op_carga = 0;
    endtask

    initial begin
        #3;
        check("rst_qp", qtd_principal, 0);
        check("rst_qs", qtd_secundario, 0);
        check("rst_ro", ro, 1);
        check("rst_min", min_principal, 1);
        check("rst_busy", busy, 0);
        check("rst_rej", carga_rejeitada, 0);
        check("rst_fim", transf_fim, 0);
        #9 clr_n = 1;
        enable = 1;
        tick();
        consumo = 1;
        tick(3);
        consumo = 0;
        check("consumo_vazio_qp", qtd_principal, 0);
        check("consumo_vazio_ro", ro, 1);

        // async reset in the middle of a load
        carga(20);
        tick(4);
        check("carga_parcial_qs", qtd_secundario, 4);
        check("carga_parcial_busy", busy, 1);
        #2 clr_n = 0;
        #1;
        check("rst_async_qs", qtd_secundario, 0);
        check("rst_async_busy", busy, 0);
        check("rst_async_ro", ro, 1);
        check("rst_async_min", min_principal, 1);
        clr_n = 1;
        tick();
        check("pos_rst_busy", busy, 0);

        // load of 20 followed by auto-transfer of 15
        carga(20);
        wait_idle(n);
        check("carga20_ciclos", n, 20);
        check("carga20_qs", qtd_secundario, 20);
        tick();
        check("transf_inicio_busy", busy, 1);
        wait_idle(n);
        check("transf15_ciclos", n, 15);
        check("transf15_qp", qtd_principal, 15);
        check("transf15_qs", qtd_secundario, 5);
        check("transf15_fim", transf_fim, 1);
        tick();
        check("transf15_fim_pulso", transf_fim, 0);
        check("transf15_idle", busy, 0);

        // batch limited by secondary stock
        clr_n = 0;
        #4 clr_n = 1;
        tick();
        carga(18);
        wait_idle(n);
        tick();
        wait_idle(n);
        check("lote_pre_qp", qtd_principal, 15);
        check("lote_pre_qs", qtd_secundario, 3);
        consumo = 1;
        tick(10);
        consumo = 0;
        check("lote_qp5", qtd_principal, 5);
        check("lote_min", min_principal, 1);
        tick();
        check("lote_busy", busy, 1);
        wait_idle(n);
        check("lote_ciclos", n, 3);
        check("lote_qp", qtd_principal, 8);
        check("lote_qs", qtd_secundario, 0);
        check("lote_min0", min_principal, 0);
        check("lote_ro0", ro, 0);
        tick(5);
        check("sem_transf_busy", busy, 0);
        check("sem_transf_qp", qtd_principal, 8);

        // rejects and capacity boundary
        carga(90);
        wait_idle(n);
        check("carga90_qs", qtd_secundario, 90);
        carga(10);
        check("rej_cap", carga_rejeitada, 1);
        check("rej_cap_busy", busy, 0);
        check("rej_cap_qs", qtd_secundario, 90);
        tick();
        check("rej_pulso", carga_rejeitada, 0);
        carga(0);
        check("rej_zero", carga_rejeitada, 1);
        enable = 0;
        carga(1);
        enable = 1;
        check("rej_enable", carga_rejeitada, 1);
        check("rej_enable_busy", busy, 0);
        carga(9);
        check("aceita9_rej", carga_rejeitada, 0);
        check("aceita9_busy", busy, 1);
        wait_idle(n);
        check("aceita9_ciclos", n, 9);
        check("cap_qs", qtd_secundario, 99);

        // consumption during transfer, and load during transfer
        consumo = 1;
        tick(3);
        consumo = 0;
        check("simul_pre_qp", qtd_principal, 5);
        tick();
        check("simul_busy", busy, 1);
        consumo = 1;
        carga(1);
        check("rej_busy", carga_rejeitada, 1);
        check("simul_1_qp", qtd_principal, 5);
        check("simul_1_qs", qtd_secundario, 98);
        wait_idle(n);
        consumo = 0;
        check("simul_ciclos", n, 14);
        check("simul_qp", qtd_principal, 5);
        check("simul_qs", qtd_secundario, 84);
        check("simul_fim", transf_fim, 1);

        // freeze mid-transfer with 7 units remaining
        tick();
        check("freeze_inicio", busy, 1);
        tick(8);
        check("freeze_pre_qp", qtd_principal, 13);
        check("freeze_pre_qs", qtd_secundario, 76);
        enable  = 0;
        consumo = 1;
        tick(10);
        check("freeze_qp", qtd_principal, 13);
        check("freeze_qs", qtd_secundario, 76);
        check("freeze_busy", busy, 1);
        check("freeze_fim", transf_fim, 0);
        consumo = 0;
        enable  = 1;
        wait_idle(n);
        check("retoma_ciclos", n, 7);
        check("retoma_qp", qtd_principal, 20);
        check("retoma_qs", qtd_secundario, 69);
        check("retoma_fim", transf_fim, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
